dmem_arbiter: RTL

- Shares the single-ported data memory (DataMemory, 32-bit words, 128 deep, word-addressed) between two requesters.
- Port 0 is the core load/store unit; port 1 is the debug/DMA loader.
- Round-robin arbitration, one transaction at a time, req/ack handshake.
- Drives the memory's writeAddress, writeData, readAddress, MemRead and MemWrite, and returns registered read data.

---
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-ported data memory between the core LSU (port 0) and a debug/DMA loader (port 1).
// Optional per-port transaction counters are enabled with the DMEM_ARB_STATS_EN macro.
module dmem_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 128
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          p0_req_i,
    input  logic          p0_we_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [DW-1:0] p0_wdata_i,
    output logic          p0_ack_o,
    output logic [DW-1:0] p0_rdata_o,
    output logic          p0_err_o,
    input  logic          p1_req_i,
    input  logic          p1_we_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wdata_i,
    output logic          p1_ack_o,
    output logic [DW-1:0] p1_rdata_o,
    output logic          p1_err_o,
    output logic [AW-1:0] mem_write_addr_o,
    output logic [DW-1:0] mem_write_data_o,
    output logic [AW-1:0] mem_read_addr_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    input  logic [DW-1:0] mem_read_data_i
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   p0_count_o,
    output logic [15:0]   p1_count_o
`endif
);

    // state | meaning
    // IDLE  | waiting for a request; grants round-robin on a tie
    // ACCESS| one cycle driving the memory for the latched transaction
    // RESP  | one-cycle ack (and err) to the served port
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic          sel_q, sel_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          in_range;

    assign in_range = (addr_q < AW'(DEPTH));

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            S_IDLE: begin
                // Port 0 wins unless it was the last one served and port 1 is waiting.
                if (p0_req_i && (!p1_req_i || last_q)) begin
                    sel_d   = 1'b0;
                    last_d  = 1'b0;
                    we_d    = p0_we_i;
                    addr_d  = p0_addr_i;
                    wdata_d = p0_wdata_i;
                    state_d = S_ACCESS;
                end else if (p1_req_i) begin
                    sel_d   = 1'b1;
                    last_d  = 1'b1;
                    we_d    = p1_we_i;
                    addr_d  = p1_addr_i;
                    wdata_d = p1_wdata_i;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    if (sel_q) rdata1_d = in_range ? mem_read_data_i : '0;
                    else       rdata0_d = in_range ? mem_read_data_i : '0;
                end
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign mem_write_addr_o = addr_q;
    assign mem_read_addr_o  = addr_q;
    assign mem_write_data_o = wdata_q;
    assign mem_write_o      = (state_q == S_ACCESS) && we_q && in_range;
    assign mem_read_o       = (state_q == S_ACCESS) && !we_q && in_range;

    assign p0_ack_o   = (state_q == S_RESP) && !sel_q;
    assign p1_ack_o   = (state_q == S_RESP) && sel_q;
    assign p0_err_o   = p0_ack_o && !in_range;
    assign p1_err_o   = p1_ack_o && !in_range;
    assign p0_rdata_o = rdata0_q;
    assign p1_rdata_o = rdata1_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (p0_ack_o && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
            if (p1_ack_o && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign p0_count_o = cnt0_q;
    assign p1_count_o = cnt1_q;
`endif

endmodule
